alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Registered y86-64 execute-stage ALU with a valid/ready handshake on both sides.
- Accepts one OPq request per cycle: addq, subq, andq or xorq. Returns a 64-bit valE one cycle later and maintains the architectural condition-code register (ZF, SF, OF).
- Sits between the decode pipeline register and the memory stage. It is the responder for the combinational 64-bit logic units, which it instantiates.

Parameters:
- W, 64, datapath width in bits.
- CNT_W, 16, width of the retired-operation counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  stage can accept a request this cycle
- in_ifun  input  4  0=addq, 1=subq, 2=andq, 3=xorq; any other value is illegal
- in_vala  input  W  valA, signed
- in_valb  input  W  valB, signed
- in_set_cc  input  1  update CC on this op
- out_valid  output  1  result held in output register
- out_ready  input  1  downstream accepts the result
- out_vale  output  W  result
- out_err  output  1  illegal ifun flag for the held result
- cc  output  3  {ZF,SF,OF}, architectural CC register
- op_count  output  CNT_W  count of accepted legal ops

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_vale=0, out_err=0, cc=3'b100 (ZF=1), op_count=0. Reset mid-operation drops any held result without a handshake.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Inputs are sampled only on accept.
  - Held out_vale, out_err and out_valid stay stable while out_valid && !out_ready.
- Latency and throughput: result is registered on the accept edge and visible the next cycle. Simultaneous accept and transfer keeps out_valid=1 with the new data, giving full throughput with no bubble.
- When a transfer happens without an accept, out_valid goes to 0 next cycle.
- Arithmetic, all in two's complement, modulo 2^W:
  - addq: vale = valb + vala; OF = (a[W-1]==b[W-1]) && (vale[W-1]!=a[W-1]).
  - subq: vale = valb - vala; OF = (a[W-1]!=b[W-1]) && (vale[W-1]!=b[W-1]).
  - andq: vale = valb & vala; OF = 0.
  - xorq: vale = valb ^ vala; OF = 0.
  - ZF = (vale==0); SF = vale[W-1].
- Illegal ifun: vale=0, out_err=1, cc unchanged, op_count unchanged. It still occupies the output slot and needs a handshake.
- CC update: cc is written on the accept edge only when the op is legal and in_set_cc=1. It is visible in the same cycle as out_valid, so a following op sees the new cc.
- op_count: increments on each accepted legal op and wraps from 2^CNT_W-1 to 0 silently.
- Backpressure: while out_valid && !out_ready, in_ready=0. An offered request stays pending with no change to cc or op_count.

Decomposition:
- Shared package alu_pkg:
  - ifun constants ALU_ADD=4'h0, ALU_SUB=4'h1, ALU_AND=4'h2, ALU_XOR=4'h3;
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0;
  - CC reset value 3'b100.
- One sub-module alu_core: combinational {ifun, vala, valb} -> {vale, zf, sf, of, illegal}. It reuses the existing 64-bit AND/XOR/adder units.
- alu_exec_stage holds the handshake, output register, cc register and counter.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, cc=3'b100, op_count=0 immediately, with no clock edge required.
- andq, a=b=-2^63, set_cc=1:
  - vale=64'h8000000000000000; cc={0,1,0}; out_valid one cycle after accept.
  - Then a=2^63-1, b=-2^63 -> vale=0, cc={1,0,0}.
  - Then a=-1, b=-2^63 -> vale=64'h8000000000000000.
- addq, a=b=2^63-1 -> vale=64'hFFFFFFFFFFFFFFFE, cc={0,1,1}.
- subq, a=1, b=-2^63 -> vale=2^63-1, cc={0,0,1}.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_vale stable, cc and op_count frozen. Then pulse out_ready=1 with a new op -> back-to-back transfer and accept with no bubble.
- Illegal and counter:
  - ifun=4'h7 -> out_err=1, vale=0, cc unchanged, op_count unchanged.
  - set_cc=0 xorq -> cc unchanged.
  - 2^16 legal ops -> op_count wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the y86-64 execute-stage ALU: function codes,
// condition-code bit positions and the CC reset value.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RST = 3'b100;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } flags_t;

endpackage

// File: rtl/alu_exec_stage_core.sv
// Combinational OPq datapath: ifun/valA/valB -> valE, flags and an illegal-ifun flag.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   ifun,
    input  logic [W-1:0] vala,
    input  logic [W-1:0] valb,
    output logic [W-1:0] vale,
    output flags_t       flags,
    output logic         illegal
);

    logic [W-1:0] sum;
    logic [W-1:0] diff;
    logic [W-1:0] andv;
    logic [W-1:0] xorv;
    logic         of_add;
    logic         of_sub;

    assign sum    = valb + vala;
    assign diff   = valb - vala;
    assign andv   = valb & vala;
    assign xorv   = valb ^ vala;
    assign of_add = (vala[W-1] == valb[W-1]) && (sum[W-1]  != vala[W-1]);
    assign of_sub = (vala[W-1] != valb[W-1]) && (diff[W-1] != valb[W-1]);

    always_comb begin
        vale     = '0;
        flags.of = 1'b0;
        illegal  = 1'b0;
        case (ifun)
            ALU_ADD: begin vale = sum;  flags.of = of_add; end
            ALU_SUB: begin vale = diff; flags.of = of_sub; end
            ALU_AND: vale = andv;
            ALU_XOR: vale = xorv;
            default: illegal = 1'b1;
        endcase
        flags.zf = (vale == '0);
        flags.sf = vale[W-1];
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute-stage ALU with valid/ready on both sides, the
// architectural {ZF,SF,OF} register and a retired-op counter.
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_ifun,
    input  logic [W-1:0]     in_vala,
    input  logic [W-1:0]     in_valb,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_vale,
    output logic             out_err,
    output logic [2:0]       cc,
    output logic [CNT_W-1:0] op_count
);

    logic [W-1:0] core_vale;
    flags_t       core_flags;
    logic         core_illegal;
    logic         accept;

    alu_core #(.W(W)) u_core (
        .ifun    (in_ifun),
        .vala    (in_vala),
        .valb    (in_valb),
        .vale    (core_vale),
        .flags   (core_flags),
        .illegal (core_illegal)
    );

    // Slot frees in the same cycle it drains, so accept and transfer can coincide.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_vale  <= '0;
            out_err   <= 1'b0;
            cc        <= CC_RST;
            op_count  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_vale  <= core_vale;
            out_err   <= core_illegal;
            if (!core_illegal) begin
                op_count <= op_count + CNT_W'(1);
                if (in_set_cc) begin
                    cc[CC_ZF] <= core_flags.zf;
                    cc[CC_SF] <= core_flags.sf;
                    cc[CC_OF] <= core_flags.of;
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: vector table plus handshake, reset and wrap sequences.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ifun;
    logic [63:0] in_vala;
    logic [63:0] in_valb;
    logic        in_set_cc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_vale;
    logic        out_err;
    logic [2:0]  cc;
    logic [15:0] op_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt;

    alu_exec_stage #(.W(64), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ifun   (in_ifun),
        .in_vala   (in_vala),
        .in_valb   (in_valb),
        .in_set_cc (in_set_cc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vale  (out_vale),
        .out_err   (out_err),
        .cc        (cc),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic        sc;
        logic [63:0] vale;
        logic        err;
        logic [2:0]  cc;
    } vec_t;

    vec_t vec [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [63:0] MINV = 64'h8000000000000000;
    localparam logic [63:0] MAXV = 64'h7FFFFFFFFFFFFFFF;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

    initial begin
        vec[0] = '{4'h2, MINV, MINV, 1'b1, MINV,                  1'b0, 3'b010};
        vec[1] = '{4'h2, MAXV, MINV, 1'b1, 64'h0,                 1'b0, 3'b100};
        vec[2] = '{4'h2, ONES, MINV, 1'b1, MINV,                  1'b0, 3'b010};
        vec[3] = '{4'h0, MAXV, MAXV, 1'b1, 64'hFFFFFFFFFFFFFFFE,  1'b0, 3'b011};
        vec[4] = '{4'h1, 64'h1, MINV, 1'b1, MAXV,                 1'b0, 3'b001};
        vec[5] = '{4'h7, 64'h5, 64'h3, 1'b1, 64'h0,               1'b1, 3'b001};
        vec[6] = '{4'h3, 64'hF0, 64'h0F, 1'b0, 64'hFF,            1'b0, 3'b001};
        vec[7] = '{4'h3, 64'h1234, 64'h1234, 1'b1, 64'h0,         1'b0, 3'b100};
        vec[8] = '{4'h0, 64'h1, 64'h2, 1'b1, 64'h3,               1'b0, 3'b000};
        vec[9] = '{4'h1, 64'h5, 64'h3, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 3'b010};

        rst_n = 1'b0; in_valid = 1'b0; in_ifun = 4'h0; in_vala = '0; in_valb = '0;
        in_set_cc = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_vale", out_vale, 64'h0);
        chk("rst_out_err", 64'(out_err), 64'(0));
        chk("rst_cc", 64'(cc), 64'(3'b100));
        chk("rst_op_count", 64'(op_count), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        exp_cnt = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table: one op per cycle, result checked right after its accept edge.
        for (int i = 0; i < 10; i++) begin
            in_ifun = vec[i].ifun; in_vala = vec[i].a; in_valb = vec[i].b;
            in_set_cc = vec[i].sc; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (!vec[i].err) exp_cnt++;
            chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(1));
            chk($sformatf("v%0d_vale", i), out_vale, vec[i].vale);
            chk($sformatf("v%0d_err", i), 64'(out_err), 64'(vec[i].err));
            chk($sformatf("v%0d_cc", i), 64'(cc), 64'(vec[i].cc));
            chk($sformatf("v%0d_cnt", i), 64'(op_count), 64'(exp_cnt));
        end
        @(posedge clk); #1;
        chk("drain_valid", 64'(out_valid), 64'(0));

        // Backpressure: hold result A while B is offered.
        out_ready = 1'b0;
        in_ifun = 4'h0; in_vala = 64'h1; in_valb = 64'h1; in_set_cc = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        exp_cnt++;
        chk("bp_a_vale", out_vale, 64'h2);
        in_ifun = 4'h0; in_vala = 64'h2; in_valb = 64'h3; in_set_cc = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'(0));
            @(posedge clk); #1;
            chk($sformatf("bp%0d_valid", c), 64'(out_valid), 64'(1));
            chk($sformatf("bp%0d_vale", c), out_vale, 64'h2);
            chk($sformatf("bp%0d_cc", c), 64'(cc), 64'(3'b000));
            chk($sformatf("bp%0d_cnt", c), 64'(op_count), 64'(exp_cnt));
        end
        out_ready = 1'b1; #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_cnt++;
        chk("b2b_valid", 64'(out_valid), 64'(1));
        chk("b2b_vale", out_vale, 64'h5);
        chk("b2b_cnt", 64'(op_count), 64'(exp_cnt));
        @(posedge clk); #1;
        chk("b2b_drain_valid", 64'(out_valid), 64'(0));

        // Reset while a result is held, between clock edges.
        out_ready = 1'b0;
        in_ifun = 4'h1; in_vala = 64'h1; in_valb = 64'h9; in_set_cc = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_cc", 64'(cc), 64'(3'b100));
        chk("mid_rst_cnt", 64'(op_count), 64'(0));
        chk("mid_rst_vale", out_vale, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Counter wrap: 2^16 streamed legal ops with set_cc=0.
        in_ifun = 4'h0; in_vala = 64'h1; in_valb = 64'h1; in_set_cc = 1'b0; in_valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_pre_cnt", 64'(op_count), 64'hFFFF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("wrap_cnt", 64'(op_count), 64'(0));
        chk("wrap_cc", 64'(cc), 64'(3'b100));
        chk("wrap_vale", out_vale, 64'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
